parity_frame_ctrl: RTL and testbench
====================================

Name: parity_frame_ctrl

Overview:
- Sequences a running-parity accumulator over serial frames.
- Frame format: start bit (0), DATA_W data bits LSB-first, one parity bit, stop bit (1).
- Collects data, checks parity and framing, and presents the result word through a valid/ready output handshake.
- Sits between a bit-serial source (one bit per bit_valid strobe) and a word-wide consumer.

Parameters:
DATA_W, 8, number of data bits per frame (2..32)
ODD_PARITY, 0, 0 = even parity (data plus parity bit carry an even count of ones); 1 = odd parity

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  reset, synchronous, active-high
bit_in  input  1  serial data bit, sampled only when bit_valid=1
bit_valid  input  1  qualifies bit_in for this cycle; cycles with bit_valid=0 advance nothing
busy  output  1  1 whenever state != IDLE
out_data  output  DATA_W  received word, bit 0 = first data bit received
out_valid  output  1  result available; held until accepted
out_ready  input  1  consumer accepts on a cycle where out_valid && out_ready
parity_err  output  1  parity check failed for the presented frame; valid while out_valid=1
frame_err  output  1  stop bit sampled as 0 for the presented frame; valid while out_valid=1
overrun  output  1  sticky; set when a frame completes while the previous result is still unaccepted

Behaviour:
- Reset (synchronous, highest priority, including mid-frame):
  - state=IDLE, bit counter=0, accumulator=0.
  - out_data=0, out_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on bit_valid=1 cycles.
- IDLE:
  - bit_in=0 -> DATA; clear accumulator; clear counter.
  - bit_in=1 -> stay in IDLE (line idle).
- DATA:
  - shift_reg[cnt] <= bit_in; acc <= acc ^ bit_in; cnt <= cnt+1.
  - When cnt==DATA_W-1 -> PARITY.
- PARITY:
  - acc <= acc ^ bit_in -> STOP.
  - Error condition: final acc != ODD_PARITY.
- STOP:
  - -> IDLE.
  - On the same edge, load out_data <= shift_reg, parity_err <= (acc != ODD_PARITY), frame_err <= ~bit_in, out_valid <= 1.
  - A bad stop bit still delivers the word, with frame_err=1.
- Latency: out_valid rises on the clock edge that samples the stop bit. Total = DATA_W+3 bit_valid strobes from the start bit.
- Handshake:
  - out_valid falls the cycle after out_valid && out_ready.
  - out_data, parity_err and frame_err are stable while out_valid=1 and not accepted.
- Simultaneous accept and frame completion on the same edge: new result loads, out_valid stays 1, no overrun.
- Completion while out_valid=1 and out_ready=0: new result overwrites the old one; overrun <= 1. overrun clears only on reset.
- Start-bit glitches are not filtered. A 0 in IDLE always starts a frame.
- Counter width: $clog2(DATA_W). No wrap beyond DATA_W-1.

Decomposition:
- Package parity_frame_pkg:
  - typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} pf_state_t.
  - localparams PAR_EVEN=0, PAR_ODD=1.
- Sub-module parity_acc: ports clk, reset, clear, en, bit_in, par.
  - Register with par <= clear ? 0 : en ? par ^ bit_in : par.
  - The FSM drives clear on start-bit detection and en in the DATA and PARITY states.

Test Plan:
1. DATA_W=8, even parity. Send start 0, data 0xA5 LSB-first, parity 0, stop 1, out_ready=1 -> out_data=0xA5, parity_err=0, frame_err=0, out_valid high for 1 cycle, busy=0 afterwards.
2. Send 0x07 with parity bit 0 -> out_data=0x07, parity_err=1, frame_err=0. Repeat with parity 1 -> parity_err=0.
3. Send 0x3C, parity 0, stop bit 0 -> out_data=0x3C, frame_err=1, parity_err=0, FSM back in IDLE.
4. Hold out_ready=0. Send frames 0x11 then 0x22 -> out_data=0x22, overrun=1. Raise out_ready -> out_valid drops next cycle; overrun stays 1 until reset.
5. Assert reset after 3 data bits -> busy=0 and all outputs 0 next cycle. Then a full 0xFF frame with parity 0 -> out_data=0xFF, parity_err=0.
6. Insert random bit_valid=0 gaps (1-4 cycles) between every bit of a 0x5A frame; ODD_PARITY=1 build with parity bit 1 -> out_data=0x5A, parity_err=0, result identical to the gap-free run.

Source files
------------

// File: rtl/parity_frame_pkg.sv
// ============================================================================
// Module   : parity_frame_pkg
// Brief    : Shared types and constants for the serial parity frame receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package parity_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } pf_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // The running XOR of data plus parity bit must equal the selected sense.
    function automatic logic par_mismatch(input logic acc, input logic odd);
        return acc != odd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/parity_frame_ctrl_acc.sv
// ============================================================================
// Module   : parity_acc
// Brief    : Single-bit running-parity register with clear and enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_acc (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic bit_in,
    output logic par
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            par <= 1'b0;
        end else if (en) begin
            par <= par ^ bit_in;
        end
    end

endmodule

`default_nettype wire

// File: rtl/parity_frame_ctrl.sv
// ============================================================================
// Module   : parity_frame_ctrl
// Brief    : Serial frame receiver (start, data LSB-first, parity, stop) with
//            parity/framing check and a valid/ready word output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_frame_ctrl
    import parity_frame_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              busy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int               CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);
    localparam logic             c_ODD  = ODD_PARITY;

    pf_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic               r_busy;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_valid;
    logic               r_parity_err;
    logic               r_frame_err;
    logic               r_overrun;

    logic               w_par;
    logic               w_clear;
    logic               w_en;

    // A 0 on an idle line always opens a frame and restarts the parity sum.
    assign w_clear = bit_valid && (r_state == IDLE) && !bit_in;
    assign w_en    = bit_valid && ((r_state == DATA) || (r_state == PARITY));

    parity_acc u_acc (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .en     (w_en),
        .bit_in (bit_in),
        .par    (w_par)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_busy       <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (bit_valid) begin
                case (r_state)
                    IDLE: begin
                        if (!bit_in) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        r_shift[r_cnt] <= bit_in;
                        if (r_cnt == c_LAST) begin
                            r_state <= PARITY;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    PARITY: begin
                        r_state <= STOP;
                    end
                    STOP: begin
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_out_data   <= r_shift;
                        r_parity_err <= par_mismatch(w_par, c_ODD);
                        r_frame_err  <= !bit_in;
                        r_out_valid  <= 1'b1;
                        // A simultaneous accept frees the slot, so only a stalled result is lost.
                        if (r_out_valid && !out_ready) begin
                            r_overrun <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy       = r_busy;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_parity_frame_ctrl.sv
// ============================================================================
// Module   : tb_parity_frame_ctrl
// Brief    : Scoreboard bench driving an even- and an odd-parity receiver
//            with the same serial stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_frame_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         bit_in;
    logic         bit_valid;
    logic         out_ready;
    logic         busy_w   [2];
    logic [W-1:0] od_w     [2];
    logic         ov_w     [2];
    logic         pe_w     [2];
    logic         fe_w     [2];
    logic         orun_w   [2];

    parity_frame_ctrl #(.DATA_W(W), .ODD_PARITY(1'b0)) u_even (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .busy(busy_w[0]), .out_data(od_w[0]), .out_valid(ov_w[0]),
        .out_ready(out_ready), .parity_err(pe_w[0]), .frame_err(fe_w[0]),
        .overrun(orun_w[0])
    );

    parity_frame_ctrl #(.DATA_W(W), .ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .busy(busy_w[1]), .out_data(od_w[1]), .out_valid(ov_w[1]),
        .out_ready(out_ready), .parity_err(pe_w[1]), .frame_err(fe_w[1]),
        .overrun(orun_w[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        bit           p;
        bit           s;
    } frm_t;

    frm_t q[$];
    bit   exp_overrun = 1'b0;
    bit   mon_en      = 1'b0;
    int   rdy_mode    = 0;
    int   total       = 0;
    int   bad         = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", name, k, act, exp, $time);
        end
    endtask

    // Parity error whenever data ones plus parity bit disagree with the chosen sense.
    function automatic bit exp_perr(input logic [W-1:0] d, input bit p, input int odd);
        return ((($countones(d) + int'(p)) % 2) != odd);
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int k = 0; k < 2; k++) begin
                    chk("valid", k, ov_w[k], q.size() > 0);
                    chk("overrun", k, orun_w[k], exp_overrun);
                    if (q.size() > 0 && ov_w[k]) begin
                        chk("data", k, od_w[k], q[0].d);
                        chk("parity_err", k, pe_w[k], exp_perr(q[0].d, q[0].p, k));
                        chk("frame_err", k, fe_w[k], !q[0].s);
                    end
                end
                if (q.size() > 0 && out_ready) begin
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input bit b, input int gap);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [W-1:0] d, input bit p, input bit s,
                              input int gmax);
        frm_t f;
        f.d = d;
        f.p = p;
        f.s = s;
        send_bit(1'b0, $urandom_range(0, gmax));
        for (int k = 0; k < 2; k++) chk("busy_start", k, busy_w[k], 1'b1);
        for (int i = 0; i < W; i++) send_bit(d[i], $urandom_range(0, gmax));
        send_bit(p, $urandom_range(0, gmax));
        bit_in    = s;
        bit_valid = 1'b1;
        @(posedge clk);
        // A result still queued at completion was never accepted: it is replaced.
        if (q.size() > 0) begin
            q[q.size()-1] = f;
            exp_overrun   = 1'b1;
        end else begin
            q.push_back(f);
        end
        #1;
        bit_valid = 1'b0;
        for (int k = 0; k < 2; k++) chk("busy_end", k, busy_w[k], 1'b0);
        repeat ($urandom_range(0, gmax)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bit_valid = 1'b0;
        @(posedge clk);
        q.delete();
        exp_overrun = 1'b0;
        #1;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", k, busy_w[k], 1'b0);
            chk("rst_data", k, od_w[k], '0);
            chk("rst_valid", k, ov_w[k], 1'b0);
            chk("rst_perr", k, pe_w[k], 1'b0);
            chk("rst_ferr", k, fe_w[k], 1'b0);
            chk("rst_overrun", k, orun_w[k], 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] rd;
        reset     = 1'b1;
        bit_in    = 1'b1;
        bit_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;
        idle(2);

        send_frame(8'hA5, 1'b0, 1'b1, 0);
        idle(3);
        send_frame(8'h07, 1'b0, 1'b1, 0);
        idle(2);
        send_frame(8'h07, 1'b1, 1'b1, 0);
        idle(2);
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        idle(2);

        rdy_mode = 1;
        idle(2);
        send_frame(8'h11, 1'b0, 1'b1, 0);
        idle(2);
        send_frame(8'h22, 1'b0, 1'b1, 0);
        idle(3);
        rdy_mode = 0;
        idle(4);

        send_bit(1'b0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        for (int k = 0; k < 2; k++) chk("busy_mid", k, busy_w[k], 1'b1);
        do_reset();
        send_frame(8'hFF, 1'b0, 1'b1, 0);
        idle(2);

        send_frame(8'h5A, 1'b1, 1'b1, 0);
        idle(2);
        send_frame(8'h5A, 1'b1, 1'b1, 4);
        idle(2);

        rdy_mode = 2;
        for (int n = 0; n < 30; n++) begin
            rd = W'($urandom);
            if ($urandom_range(0, 3) == 0) send_bit(1'b1, $urandom_range(0, 2));
            send_frame(rd, 1'($urandom), ($urandom_range(0, 7) != 0), 3);
        end

        rdy_mode = 0;
        idle(6);
        chk("drain", 0, q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
